// File: rtl/hcam_pkg.sv
// Shared widths, FSM state encoding and entry field helpers for the hcam lookup slice.
// Entry layout, LSB first: valid, key, result; a time field above the result is reserved and kept zero.
// No logic here: constants, types and pure functions only.
package hcam_pkg;
  localparam int SN = 4;
  localparam int HW = 6;
  localparam int DW = 19;
  localparam int RW = 20;
  localparam int TW = 0;
  localparam int EW = TW + RW + DW + 1;
  localparam int LW = EW * SN;
  localparam int SL = $clog2(SN);

  localparam int VALID_BIT = 0;
  localparam int KEY_LSB   = 1;
  localparam int RES_LSB   = DW + 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_CMP   = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  typedef logic [EW-1:0] entry_t;
  typedef logic [LW-1:0] line_t;

  function automatic entry_t get_slot(line_t l, int i);
    return l[EW*i +: EW];
  endfunction

  function automatic logic ent_valid(entry_t e);
    return e[VALID_BIT];
  endfunction

  function automatic logic [DW-1:0] ent_key(entry_t e);
    return e[KEY_LSB +: DW];
  endfunction

  function automatic logic [RW-1:0] ent_result(entry_t e);
    return e[RES_LSB +: RW];
  endfunction

  function automatic entry_t make_entry(logic [DW-1:0] k, logic [RW-1:0] r);
    entry_t e;
    e = '0;
    e[VALID_BIT]     = 1'b1;
    e[KEY_LSB +: DW] = k;
    e[RES_LSB +: RW] = r;
    return e;
  endfunction
endpackage

// File: rtl/hcam_lookup_ctrl_if.sv
// Request/response handshake bundle between a requester (master) and hcam_lookup_ctrl (slave).
// Latency: none, wires only.
// Backpressure: req_valid/req_ready on the request side, rsp_valid/rsp_ready on the response side.
interface hcam_lookup_ctrl_if;
  import hcam_pkg::*;

  logic          req_valid;
  logic          req_ready;
  logic          req_op;
  logic [DW-1:0] req_key;
  logic [RW-1:0] req_result;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_hit;
  logic [RW-1:0] rsp_result;
  logic          rsp_full;

  modport master (
    output req_valid, req_op, req_key, req_result, rsp_ready,
    input  req_ready, rsp_valid, rsp_hit, rsp_result, rsp_full
  );

  modport slave (
    input  req_valid, req_op, req_key, req_result, rsp_ready,
    output req_ready, rsp_valid, rsp_hit, rsp_result, rsp_full
  );
endinterface

// File: rtl/hcam_hash.sv
// Two independent line addresses per key: fold(key) and fold(bit-reversed key).
// Latency: combinational.
// Backpressure: none.
module hcam_hash
  import hcam_pkg::*;
(
  input  logic [DW-1:0] key,
  output logic [HW-1:0] hash_a,
  output logic [HW-1:0] hash_b
);
  localparam int NCH = (DW + HW - 1) / HW;
  localparam int PW  = NCH * HW;

  // The top chunk is zero-padded by widening before slicing.
  function automatic logic [HW-1:0] fold(logic [DW-1:0] x);
    logic [PW-1:0] p;
    logic [HW-1:0] h;
    p = PW'(x);
    h = '0;
    for (int c = 0; c < NCH; c++) h = h ^ p[c*HW +: HW];
    return h;
  endfunction

  function automatic logic [DW-1:0] reverse(logic [DW-1:0] x);
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i++) r[i] = x[DW-1-i];
    return r;
  endfunction

  assign hash_a = fold(key);
  assign hash_b = fold(reverse(key));
endmodule

// File: rtl/hcam_lookup_ctrl.sv
// Search/insert controller for a two-way multi-hash RAM pair; HCAM_UPDATE_EN enables in-place result update.
// Latency: response 3 cycles after accept, 4 when an insert writes a line.
// Backpressure: one request in flight; req_ready low until the cycle after the rsp handshake.
module hcam_lookup_ctrl
  import hcam_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  hcam_lookup_ctrl_if.slave bus,
  output logic [HW-1:0]     rama_addra_o,
  input  logic [LW-1:0]     rama_douta_i,
  output logic              rama_web_o,
  output logic [HW-1:0]     rama_addrb_o,
  output logic [LW-1:0]     rama_dinb_o,
  output logic [HW-1:0]     ramb_addra_o,
  input  logic [LW-1:0]     ramb_douta_i,
  output logic              ramb_web_o,
  output logic [HW-1:0]     ramb_addrb_o,
  output logic [LW-1:0]     ramb_dinb_o
);
  logic [2:0]    state, state_n;
  logic          ready_q, op_q, wr_b_q, hit_q, full_q;
  logic [DW-1:0] key_q;
  logic [RW-1:0] res_q, result_q;
  logic [HW-1:0] ha_q, hb_q, hash_a, hash_b;
  logic [LW-1:0] line_q;

  logic          accept;
  logic          hit, hit_b, free_a, free_b, do_write, full, tgt_b;
  logic [SL-1:0] hit_slot, slot_a, slot_b, tgt_slot;
  logic [RW-1:0] hit_res, rsp_res_n;
  logic [LW-1:0] hit_line, new_line;

  hcam_hash u_hash (.key(bus.req_key), .hash_a(hash_a), .hash_b(hash_b));

  assign accept = bus.req_valid && ready_q;

  // Scans run high-to-low so the lowest index wins; B is scanned before A so A wins overall.
  always_comb begin
    hit = 1'b0; hit_b = 1'b0; hit_slot = '0;
    free_a = 1'b0; slot_a = '0; free_b = 1'b0; slot_b = '0;
    for (int i = SN-1; i >= 0; i--) begin
      if (!ent_valid(get_slot(ramb_douta_i, i))) begin free_b = 1'b1; slot_b = SL'(i); end
      if (ent_valid(get_slot(ramb_douta_i, i)) && ent_key(get_slot(ramb_douta_i, i)) == key_q) begin
        hit = 1'b1; hit_b = 1'b1; hit_slot = SL'(i);
      end
    end
    for (int i = SN-1; i >= 0; i--) begin
      if (!ent_valid(get_slot(rama_douta_i, i))) begin free_a = 1'b1; slot_a = SL'(i); end
      if (ent_valid(get_slot(rama_douta_i, i)) && ent_key(get_slot(rama_douta_i, i)) == key_q) begin
        hit = 1'b1; hit_b = 1'b0; hit_slot = SL'(i);
      end
    end
  end

  assign hit_line = hit_b ? ramb_douta_i : rama_douta_i;
  assign hit_res  = ent_result(get_slot(hit_line, int'(hit_slot)));

  always_comb begin
    do_write = 1'b0; full = 1'b0; tgt_b = 1'b0; tgt_slot = '0;
    if (op_q) begin
      if (hit) begin
`ifdef HCAM_UPDATE_EN
        do_write = 1'b1; tgt_b = hit_b; tgt_slot = hit_slot;
`endif
      end else if (free_a) begin
        do_write = 1'b1; tgt_slot = slot_a;
      end else if (free_b) begin
        do_write = 1'b1; tgt_b = 1'b1; tgt_slot = slot_b;
      end else begin
        full = 1'b1;
      end
    end
    new_line = tgt_b ? ramb_douta_i : rama_douta_i;
    new_line[EW*tgt_slot +: EW] = make_entry(key_q, res_q);
`ifdef HCAM_UPDATE_EN
    rsp_res_n = !hit ? '0 : (op_q ? res_q : hit_res);
`else
    rsp_res_n = hit ? hit_res : '0;
`endif
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (accept) state_n = ST_READ;
      ST_READ:  state_n = ST_CMP;
      ST_CMP:   state_n = do_write ? ST_WRITE : ST_RESP;
      ST_WRITE: state_n = ST_RESP;
      ST_RESP:  if (bus.rsp_ready) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE; ready_q <= 1'b0;
      op_q <= 1'b0; key_q <= '0; res_q <= '0; ha_q <= '0; hb_q <= '0;
      hit_q <= 1'b0; full_q <= 1'b0; result_q <= '0; line_q <= '0; wr_b_q <= 1'b0;
    end else begin
      state   <= state_n;
      ready_q <= (state_n == ST_IDLE);
      if (state == ST_IDLE && accept) begin
        op_q <= bus.req_op; key_q <= bus.req_key; res_q <= bus.req_result;
        ha_q <= hash_a;     hb_q <= hash_b;
      end
      if (state == ST_CMP) begin
        hit_q <= hit; full_q <= full; result_q <= rsp_res_n;
        if (do_write) begin
          line_q <= new_line; wr_b_q <= tgt_b;
        end
      end
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.rsp_valid  = (state == ST_RESP);
  assign bus.rsp_hit    = hit_q;
  assign bus.rsp_full   = full_q;
  assign bus.rsp_result = result_q;

  assign rama_addra_o = ha_q;
  assign ramb_addra_o = hb_q;
  assign rama_addrb_o = ha_q;
  assign ramb_addrb_o = hb_q;
  assign rama_dinb_o  = line_q;
  assign ramb_dinb_o  = line_q;
  assign rama_web_o   = (state == ST_WRITE) && !wr_b_q;
  assign ramb_web_o   = (state == ST_WRITE) &&  wr_b_q;
endmodule

// File: tb/tb_hcam_lookup_ctrl.sv
// Bench for hcam_lookup_ctrl: RAM pair models plus a slot-level reference model of the hash table.
module tb_hcam_lookup_ctrl;
  import hcam_pkg::*;

  localparam int NL = 1 << HW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hcam_lookup_ctrl_if bus();

  logic [HW-1:0] a_addra, b_addra, a_addrb, b_addrb;
  logic [LW-1:0] a_douta, b_douta, a_dinb, b_dinb;
  logic          a_web, b_web;
  logic [LW-1:0] mem_a [NL] = '{default: '0};
  logic [LW-1:0] mem_b [NL] = '{default: '0};

  always @(posedge clk) begin
    a_douta <= mem_a[a_addra];
    b_douta <= mem_b[b_addra];
    if (a_web) mem_a[a_addrb] <= a_dinb;
    if (b_web) mem_b[b_addrb] <= b_dinb;
  end

  hcam_lookup_ctrl dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .rama_addra_o(a_addra), .rama_douta_i(a_douta), .rama_web_o(a_web),
    .rama_addrb_o(a_addrb), .rama_dinb_o(a_dinb),
    .ramb_addra_o(b_addra), .ramb_douta_i(b_douta), .ramb_web_o(b_web),
    .ramb_addrb_o(b_addrb), .ramb_dinb_o(b_dinb)
  );

  // Reference model: table[ram][line][slot] of (valid, key, result).
  bit            mval [2][NL][SN];
  logic [DW-1:0] mkey [2][NL][SN];
  logic [RW-1:0] mres [2][NL][SN];

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Address bit j collects every key bit whose position is congruent to j modulo HW.
  function automatic logic [HW-1:0] m_hash(input logic [DW-1:0] k, input bit rev);
    logic [HW-1:0] h;
    h = '0;
    for (int b = 0; b < DW; b++) h[b % HW] = h[b % HW] ^ (rev ? k[DW-1-b] : k[b]);
    return h;
  endfunction

  function automatic logic [LW-1:0] m_line(input int r, input int a);
    logic [LW-1:0] l;
    l = '0;
    for (int s = 0; s < SN; s++) if (mval[r][a][s]) begin
      l[EW*s]               = 1'b1;
      l[EW*s + 1 +: DW]     = mkey[r][a][s];
      l[EW*s + DW + 1 +: RW] = mres[r][a][s];
    end
    return l;
  endfunction

  task automatic check_reset_vals(input string p);
    check({p, "_req_ready"},  LW'(bus.req_ready), '0);
    check({p, "_rsp_valid"},  LW'(bus.rsp_valid), '0);
    check({p, "_rsp_hit"},    LW'(bus.rsp_hit), '0);
    check({p, "_rsp_full"},   LW'(bus.rsp_full), '0);
    check({p, "_rsp_result"}, LW'(bus.rsp_result), '0);
    check({p, "_webs"},       LW'({a_web, b_web}), '0);
    check({p, "_addrs"},      LW'({a_addra, b_addra, a_addrb, b_addrb}), '0);
    check({p, "_dinb"},       a_dinb | b_dinb, '0);
  endtask

  task automatic run_req(input bit op, input logic [DW-1:0] key, input logic [RW-1:0] res, input int hold);
    int ad [2];
    bit hit, exp_wr, exp_full;
    int hr, hs, wr, ws, web_c, rsp_c, web_cnt, web_ram;
    logic [RW-1:0] exp_res;
    logic [LW-1:0] exp_line, got_line;
    logic [HW-1:0] got_addr;

    ad[0] = int'(m_hash(key, 1'b0));
    ad[1] = int'(m_hash(key, 1'b1));
    hit = 0; hr = 0; hs = 0; wr = -1; ws = -1;
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < SN; s++) begin
        if (!hit && mval[r][ad[r]][s] && mkey[r][ad[r]][s] == key) begin hit = 1; hr = r; hs = s; end
        if (wr < 0 && !mval[r][ad[r]][s]) begin wr = r; ws = s; end
      end
    exp_res = hit ? mres[hr][ad[hr]][hs] : '0;
    exp_wr = 0; exp_full = 0;
    if (op) begin
      if (hit) begin
`ifdef HCAM_UPDATE_EN
        exp_wr = 1; wr = hr; ws = hs; exp_res = res;
`endif
      end else if (wr >= 0) exp_wr = 1;
      else exp_full = 1;
    end
    exp_line = '0;
    if (exp_wr) begin
      mval[wr][ad[wr]][ws] = 1; mkey[wr][ad[wr]][ws] = key; mres[wr][ad[wr]][ws] = res;
      exp_line = m_line(wr, ad[wr]);
    end

    bus.rsp_ready = (hold == 0);
    @(negedge clk);
    check("req_ready_idle", LW'(bus.req_ready), LW'(1));
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_key = key; bus.req_result = res;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    web_c = -1; rsp_c = -1; web_cnt = 0; web_ram = -1; got_line = '0; got_addr = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (a_web || b_web) begin
        web_cnt++;
        if (web_c < 0) begin
          web_c = c; web_ram = b_web ? 1 : 0;
          got_line = b_web ? b_dinb : a_dinb; got_addr = b_web ? b_addrb : a_addrb;
        end
      end
      if (bus.rsp_valid) begin rsp_c = c; break; end
    end
    check("rsp_cycle", LW'(rsp_c), LW'(exp_wr ? 4 : 3));
    check("web_cycle", LW'(web_c), LW'(exp_wr ? 3 : -1));
    check("web_count", LW'(web_cnt), LW'(exp_wr ? 1 : 0));
    if (exp_wr) begin
      check("web_ram",   LW'(web_ram), LW'(wr));
      check("wr_addr",   LW'(got_addr), LW'(ad[wr]));
      check("wr_line",   got_line, exp_line);
    end
    check("rsp_hit",    LW'(bus.rsp_hit), LW'(hit));
    check("rsp_full",   LW'(bus.rsp_full), LW'(exp_full));
    check("rsp_result", LW'(bus.rsp_result), LW'(exp_res));

    if (hold > 0) begin
      bus.req_valid = 1'b1; bus.req_op = 1'b1; bus.req_key = ~key;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check("hold_valid",  LW'(bus.rsp_valid), LW'(1));
        check("hold_ready",  LW'(bus.req_ready), '0);
        check("hold_fields", LW'({bus.rsp_hit, bus.rsp_full, bus.rsp_result}), LW'({hit, exp_full, exp_res}));
        check("hold_web",    LW'({a_web, b_web}), '0);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      check("post_hold_ready", LW'(bus.req_ready), LW'(1));
      check("post_hold_valid", LW'(bus.rsp_valid), '0);
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [DW-1:0] kb, rk;
    logic [DW-1:0] keys [9];
    logic [DW-1:0] pool [10];
    logic [DW-1:0] pat;
    int ha, hb;
    bit empty;

    bus.req_valid = 1'b0; bus.req_op = 1'b0; bus.req_key = '0; bus.req_result = '0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_req(1'b1, 19'h00001, 20'hABCDE, 0);
    check("first_write_landed", mem_a[1][EW-1:0], LW'({20'hABCDE, 19'h00001, 1'b1}));
    run_req(1'b0, 19'h00001, '0, 0);
    run_req(1'b0, 19'h00002, '0, 0);

    // Nine keys that differ only by patterns invisible to both hashes.
    do begin
      kb = DW'($urandom);
      ha = int'(m_hash(kb, 1'b0)); hb = int'(m_hash(kb, 1'b1));
      empty = 1;
      for (int s = 0; s < SN; s++) if (mval[0][ha][s] || mval[1][hb][s]) empty = 0;
    end while (!empty);
    for (int i = 0; i < 9; i++) begin
      pat = '0; pat[i] = 1'b1; pat[i+6] = 1'b1;
      keys[i] = kb ^ pat;
    end
    for (int i = 0; i < 9; i++) run_req(1'b1, keys[i], RW'($urandom), 0);
    check("full_slots_a", LW'(mval[0][ha][0] & mval[0][ha][3]), LW'(1));
    run_req(1'b0, keys[6], '0, 0);

    run_req(1'b1, 19'h00001, 20'h12345, 0);
    run_req(1'b0, 19'h00001, '0, 5);

    // Reset during READ of an insert: nothing may be written.
    do rk = DW'($urandom); while (rk == 19'h00001);
    for (int s = 0; s < SN; s++) begin
      if (mval[0][m_hash(rk, 1'b0)][s] && mkey[0][m_hash(rk, 1'b0)][s] == rk) rk = rk ^ 19'h40000;
      if (mval[1][m_hash(rk, 1'b1)][s] && mkey[1][m_hash(rk, 1'b1)][s] == rk) rk = rk ^ 19'h40000;
    end
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 1'b1; bus.req_key = rk; bus.req_result = 20'h55555;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset_vals("midreset");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("midreset_web", LW'({a_web, b_web}), '0);
    end
    rst_n = 1'b1;
    run_req(1'b0, rk, '0, 0);

    for (int i = 0; i < 10; i++) pool[i] = DW'($urandom);
    for (int n = 0; n < 40; n++)
      run_req(1'($urandom_range(0, 1)), pool[$urandom_range(0, 9)], RW'($urandom),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
